// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: line and baud tick into the receiver, parsed frame back to the host.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 sample_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;

    modport slave (
        input  sample_tick, rx_in,
        output rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

    modport master (
        output sample_tick, rx_in,
        input  rx_data, rx_valid, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled mid-bit sampling, LSB-first shift, parity/stop check, one-clock valid strobe.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line watch; arms on a high sample, a low sample when armed starts a frame
// S_START  | wait half a bit, confirm the start bit is still low
// S_DATA   | sample DATA_BITS data bits, one per bit period
// S_PARITY | sample parity bit and latch the mismatch
// S_STOP   | sample stop bit, publish the frame with rx_valid
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic     clock,
    input  logic     reset_n,
    uart_rx_if.slave bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [1:0]           r_sync;
    state_t               r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_armed;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_lat;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_rx_valid;

    logic                 w_rx_s;
    state_t               w_state_next;
    logic [TW-1:0]        w_tick_next;
    logic [BW-1:0]        w_bit_next;
    logic                 w_armed_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_perr_lat_next;
    logic [DATA_BITS-1:0] w_rx_data_next;
    logic                 w_parity_err_next;
    logic                 w_frame_err_next;
    logic                 w_rx_valid_next;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync       <= 2'b11;
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_armed      <= 1'b0;
            r_shift      <= '0;
            r_perr_lat   <= 1'b0;
            r_rx_data    <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_valid   <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], bus.rx_in};
            r_state      <= w_state_next;
            r_tick_cnt   <= w_tick_next;
            r_bit_cnt    <= w_bit_next;
            r_armed      <= w_armed_next;
            r_shift      <= w_shift_next;
            r_perr_lat   <= w_perr_lat_next;
            r_rx_data    <= w_rx_data_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
            r_rx_valid   <= w_rx_valid_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_tick_next       = r_tick_cnt;
        w_bit_next        = r_bit_cnt;
        w_armed_next      = r_armed;
        w_shift_next      = r_shift;
        w_perr_lat_next   = r_perr_lat;
        w_rx_data_next    = r_rx_data;
        w_parity_err_next = r_parity_err;
        w_frame_err_next  = r_frame_err;
        w_rx_valid_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.sample_tick) begin
                    if (r_armed && !w_rx_s) begin
                        w_state_next = S_START;
                        w_tick_next  = '0;
                        w_armed_next = 1'b0;
                    end else if (w_rx_s) begin
                        w_armed_next = 1'b1;
                    end
                end
            end
            S_START: begin
                if (bus.sample_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        w_tick_next = '0;
                        // A high line at mid-start is a glitch: drop it silently.
                        if (w_rx_s) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next    = S_DATA;
                            w_bit_next      = '0;
                            w_perr_lat_next = 1'b0;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.sample_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_next  = '0;
                        w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_next   = '0;
                            w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bus.sample_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_next     = '0;
                        w_perr_lat_next = w_rx_s ^ (^r_shift) ^ ODD_BIT;
                        w_state_next    = S_STOP;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bus.sample_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_next       = '0;
                        w_rx_data_next    = r_shift;
                        w_parity_err_next = (PARITY_EN != 0) ? r_perr_lat : 1'b0;
                        w_frame_err_next  = !w_rx_s;
                        w_rx_valid_next   = 1'b1;
                        // Disarm so a held-low break cannot look like a new start bit.
                        w_armed_next      = 1'b0;
                        w_state_next      = S_IDLE;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tick_next  = '0;
                w_bit_next   = '0;
                w_armed_next = 1'b0;
            end
        endcase
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.rx_busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives whole frames bit-by-bit and compares strobed results with a frame-level model.
module tb_uart_rx;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int ODD      = 0;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   n_strobes;
    logic [DB-1:0] cap_data;
    logic          cap_pe;
    logic          cap_fe;
    logic [DB-1:0] exp_data;
    logic          exp_pe;
    logic          exp_fe;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_EN  (1),
        .PARITY_ODD (ODD)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        int c;
        c = 0;
        bus.sample_tick = 1'b0;
        forever begin
            @(negedge clock);
            c = (c == TICK_DIV - 1) ? 0 : c + 1;
            bus.sample_tick = (c == 0);
        end
    end

    // Strobe recorder: each cycle rx_valid is high counts as one strobe.
    initial begin
        n_strobes = 0;
        cap_data  = '0;
        cap_pe    = 1'b0;
        cap_fe    = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.rx_valid === 1'b1) begin
                n_strobes++;
                cap_data = bus.rx_data;
                cap_pe   = bus.parity_err;
                cap_fe   = bus.frame_err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ (ODD != 0);
    endfunction

    task automatic send_bit(input logic b);
        bus.rx_in = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic expect_frame(input string name, input int s0,
                                input logic [DB-1:0] d, input logic pe, input logic fe);
        exp_data = d;
        exp_pe   = pe;
        exp_fe   = fe;
    endtask

    task automatic test_reset();
        logic [DB+3:0] obs;
        reset_n   = 1'b0;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clock);
        obs = {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        vectors++;
        if (bus.rx_busy !== 1'b0 || n_strobes !== 0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b strobes=%0d want busy=0 strobes=0", bus.rx_busy, n_strobes);
        end
        exp_data = '0; exp_pe = 1'b0; exp_fe = 1'b0;
    endtask

    task automatic test_good_frame();
        int s0;
        s0 = n_strobes;
        send_frame(8'hA5, good_par(8'hA5), 1'b1);
        expect_frame("good", s0, 8'hA5, 1'b0, 1'b0);
        vectors++;
        if (n_strobes !== s0 + 1) begin
            miscompares++;
            $display("FAIL good_strobes: got %0d want 1", n_strobes - s0);
        end
        vectors++;
        if ({cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
            miscompares++;
            $display("FAIL good_frame: got data=%h pe=%b fe=%b want data=%h pe=%b fe=%b",
                     cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
        end
        send_bit(1'b1);
        vectors++;
        if (bus.rx_busy !== 1'b0 || bus.rx_data !== exp_data) begin
            miscompares++;
            $display("FAIL good_hold: got busy=%b data=%h want busy=0 data=%h", bus.rx_busy, bus.rx_data, exp_data);
        end
    endtask

    task automatic test_parity_err();
        logic [DB-1:0] d;
        int s0;
        for (int k = 0; k < 2; k++) begin
            d  = (k == 0) ? 8'hA5 : 8'h3C;
            s0 = n_strobes;
            send_frame(d, good_par(d) ^ (k == 0), 1'b1);
            expect_frame("parity", s0, d, (k == 0), 1'b0);
            vectors++;
            if (n_strobes !== s0 + 1 || {cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
                miscompares++;
                $display("FAIL parity_frame%0d: got n=%0d data=%h pe=%b fe=%b want n=1 data=%h pe=%b fe=%b",
                         k, n_strobes - s0, cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
            end
            send_bit(1'b1);
        end
    endtask

    task automatic test_break();
        int s0;
        s0 = n_strobes;
        send_frame(8'h6E, good_par(8'h6E), 1'b0);
        repeat (3) send_bit(1'b0);
        expect_frame("break", s0, 8'h6E, 1'b0, 1'b1);
        vectors++;
        if (n_strobes !== s0 + 1 || {cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
            miscompares++;
            $display("FAIL break_frame: got n=%0d data=%h pe=%b fe=%b want n=1 data=%h pe=%b fe=%b",
                     n_strobes - s0, cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
        end
        send_bit(1'b1);
        s0 = n_strobes;
        send_frame(8'h81, good_par(8'h81), 1'b1);
        expect_frame("after_break", s0, 8'h81, 1'b0, 1'b0);
        vectors++;
        if (n_strobes !== s0 + 1 || {cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
            miscompares++;
            $display("FAIL after_break: got n=%0d data=%h pe=%b fe=%b want n=1 data=%h pe=%b fe=%b",
                     n_strobes - s0, cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
        end
        send_bit(1'b1);
    endtask

    task automatic test_false_start();
        int s0;
        s0 = n_strobes;
        bus.rx_in = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clock);
        vectors++;
        if (bus.rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL false_start_busy: got %b want 1", bus.rx_busy);
        end
        bus.rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        vectors++;
        if (bus.rx_busy !== 1'b0 || n_strobes !== s0 ||
            {bus.rx_data, bus.parity_err, bus.frame_err} !== {exp_data, exp_pe, exp_fe}) begin
            miscompares++;
            $display("FAIL false_start: got busy=%b n=%0d data=%h pe=%b fe=%b want busy=0 n=0 data=%h pe=%b fe=%b",
                     bus.rx_busy, n_strobes - s0, bus.rx_data, bus.parity_err, bus.frame_err,
                     exp_data, exp_pe, exp_fe);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = n_strobes;
        send_frame(8'h00, good_par(8'h00), 1'b1);
        vectors++;
        if (n_strobes !== s0 + 1 || cap_data !== 8'h00 || cap_pe !== 1'b0 || cap_fe !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got n=%0d data=%h pe=%b fe=%b want n=1 data=00 pe=0 fe=0",
                     n_strobes - s0, cap_data, cap_pe, cap_fe);
        end
        send_frame(8'hFF, good_par(8'hFF), 1'b1);
        expect_frame("b2b", s0, 8'hFF, 1'b0, 1'b0);
        vectors++;
        if (n_strobes !== s0 + 2 || {cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
            miscompares++;
            $display("FAIL b2b_second: got n=%0d data=%h pe=%b fe=%b want n=2 data=%h pe=%b fe=%b",
                     n_strobes - s0, cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
        end
        send_bit(1'b1);
    endtask

    task automatic test_midframe_reset();
        logic [DB-1:0] d;
        logic [DB+3:0] obs;
        int s0;
        d  = 8'h33;
        s0 = n_strobes;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        bus.rx_in = d[3];
        repeat (BIT_CLKS / 2) @(negedge clock);
        vectors++;
        if (bus.rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_busy_before: got %b want 1", bus.rx_busy);
        end
        reset_n = 1'b0;
        #1;
        obs = {bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h want 0", obs);
        end
        repeat (2) @(negedge clock);
        reset_n   = 1'b1;
        bus.rx_in = 1'b1;
        exp_data = '0; exp_pe = 1'b0; exp_fe = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clock);
        vectors++;
        if (n_strobes !== s0 || bus.rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_discard: got n=%0d busy=%b want n=0 busy=0", n_strobes - s0, bus.rx_busy);
        end
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        expect_frame("after_reset", s0, 8'h5A, 1'b0, 1'b0);
        vectors++;
        if (n_strobes !== s0 + 1 || {cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
            miscompares++;
            $display("FAIL after_reset: got n=%0d data=%h pe=%b fe=%b want n=1 data=%h pe=%b fe=%b",
                     n_strobes - s0, cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
        end
        send_bit(1'b1);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [DB-1:0] d;
            logic flip;
            logic stop;
            int s0;
            d    = DB'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            s0   = n_strobes;
            send_frame(d, good_par(d) ^ flip, stop);
            expect_frame("random", s0, d, flip, !stop);
            if (!stop) repeat ($urandom_range(0, 2)) send_bit(1'b0);
            vectors++;
            if (n_strobes !== s0 + 1 || {cap_data, cap_pe, cap_fe} !== {exp_data, exp_pe, exp_fe}) begin
                miscompares++;
                $display("FAIL random%0d: got n=%0d data=%h pe=%b fe=%b want n=1 data=%h pe=%b fe=%b",
                         i, n_strobes - s0, cap_data, cap_pe, cap_fe, exp_data, exp_pe, exp_fe);
            end
            bus.rx_in = 1'b1;
            if (!stop) repeat (BIT_CLKS) @(negedge clock);
            else repeat ($urandom_range(0, 2 * BIT_CLKS)) @(negedge clock);
        end
        send_bit(1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.rx_in   = 1'b1;
        exp_data    = '0;
        exp_pe      = 1'b0;
        exp_fe      = 1'b0;
        @(negedge clock);
        test_reset();
        test_good_frame();
        test_parity_err();
        test_break();
        test_false_start();
        test_back_to_back();
        test_midframe_reset();
        test_random(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
